rdm_rx_parser: RTL and testbench

//  Receive side of the RDM location-message protocol. Consumes bytes from the UART receiver,

---
 rtl/rdm_pkg.sv | 51 +++++
 rtl/rdm_loc_decode.sv | 40 ++++
 rtl/rdm_rx_parser.sv | 152 +++++++++++++++
 tb/tb_rdm_rx_parser.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rdm_pkg.sv
// Shared constants for the RDM location-message protocol: place-node codes,
// ASCII bytes used in frames, receive FSM states and error codes.
package rdm_pkg;

  // Place-node codes (shared with the RDM transmitter)
  localparam logic [4:0] NODE_PSU1 = 5'd27;
  localparam logic [4:0] NODE_PSU2 = 5'd29;
  localparam logic [4:0] NODE_PSU3 = 5'd31;
  localparam logic [4:0] NODE_MU1  = 5'd9;
  localparam logic [4:0] NODE_MU2  = 5'd8;
  localparam logic [4:0] NODE_MU3  = 5'd7;
  localparam logic [4:0] NODE_FSU1 = 5'd25;
  localparam logic [4:0] NODE_FSU2 = 5'd22;
  localparam logic [4:0] NODE_FSU3 = 5'd20;
  localparam logic [4:0] NODE_WSU1 = 5'd17;
  localparam logic [4:0] NODE_WSU2 = 5'd15;
  localparam logic [4:0] NODE_WSU3 = 5'd13;

  // ASCII bytes
  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_D     = 8'h44;
  localparam logic [7:0] CH_M     = 8'h4D;
  localparam logic [7:0] CH_DASH  = 8'h2D;
  localparam logic [7:0] CH_HASH  = 8'h23;
  localparam logic [7:0] CH_P     = 8'h50;
  localparam logic [7:0] CH_F     = 8'h46;
  localparam logic [7:0] CH_W     = 8'h57;
  localparam logic [7:0] CH_S     = 8'h53;
  localparam logic [7:0] CH_U     = 8'h55;
  localparam logic [7:0] CH_1     = 8'h31;
  localparam logic [7:0] CH_2     = 8'h32;
  localparam logic [7:0] CH_3     = 8'h33;
  localparam logic [7:0] CH_SPACE = 8'h20;

  // Receive FSM states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_H_D    = 3'd1,
    S_H_M    = 3'd2,
    S_H_DASH = 3'd3,
    S_LOC    = 3'd4,
    S_TERM   = 3'd5
  } rdm_state_t;

  // Error codes reported with msg_error
  localparam logic [1:0] ERR_HEADER  = 2'd0;
  localparam logic [1:0] ERR_LOC     = 2'd1;
  localparam logic [1:0] ERR_TERM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/rdm_loc_decode.sv
// Combinational decoder: maps the buffered LOC text (first char in loc_buf[0])
// and its length to a place-node code. Only exact upper-case matches are known.
module rdm_loc_decode
  import rdm_pkg::*;
(
  input  logic [3:0][7:0] loc_buf,
  input  logic [2:0]      loc_len,
  output logic [4:0]      node,
  output logic            known
);

  // Match "MUn" (3 chars) or "PSUn"/"FSUn"/"WSUn" (4 chars)
  always_comb begin
    node  = 5'd0;
    known = 1'b0;
    if (loc_len == 3'd3 && loc_buf[0] == CH_M && loc_buf[1] == CH_U) begin
      case (loc_buf[2])
        CH_1:    begin node = NODE_MU1; known = 1'b1; end
        CH_2:    begin node = NODE_MU2; known = 1'b1; end
        CH_3:    begin node = NODE_MU3; known = 1'b1; end
        default: begin node = 5'd0;     known = 1'b0; end
      endcase
    end else if (loc_len == 3'd4 && loc_buf[1] == CH_S && loc_buf[2] == CH_U) begin
      known = 1'b1;
      case ({loc_buf[0], loc_buf[3]})
        {CH_P, CH_1}: node = NODE_PSU1;
        {CH_P, CH_2}: node = NODE_PSU2;
        {CH_P, CH_3}: node = NODE_PSU3;
        {CH_F, CH_1}: node = NODE_FSU1;
        {CH_F, CH_2}: node = NODE_FSU2;
        {CH_F, CH_3}: node = NODE_FSU3;
        {CH_W, CH_1}: node = NODE_WSU1;
        {CH_W, CH_2}: node = NODE_WSU2;
        {CH_W, CH_3}: node = NODE_WSU3;
        default: begin node = 5'd0; known = 1'b0; end
      endcase
    end
  end

endmodule

// File: rtl/rdm_rx_parser.sv
// RDM receive parser: consumes UART RX bytes, parses "RDM-<LOC>-#" frames and
// emits the place-node code, or an error pulse for malformed/unknown/stalled frames.
module rdm_rx_parser
  import rdm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             msg_valid,
  output logic [4:0]       place_node,
  output logic             msg_error,
  output logic [1:0]       err_code,
  output logic             busy,
  output logic [CNT_W-1:0] msg_count
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  rdm_state_t       state_q, state_d;
  logic [3:0][7:0]  loc_buf_q, loc_buf_d;
  logic [2:0]       loc_len_q, loc_len_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             msg_valid_d, msg_error_d;
  logic [1:0]       err_code_d;
  logic [4:0]       place_node_d;
  logic [CNT_W-1:0] msg_count_d;
  logic [4:0]       dec_node;
  logic             dec_known;

  rdm_loc_decode u_decode (
    .loc_buf (loc_buf_q),
    .loc_len (loc_len_q),
    .node    (dec_node),
    .known   (dec_known)
  );

  // Next-state, buffer, timeout and output-register logic
  always_comb begin
    state_d      = state_q;
    loc_buf_d    = loc_buf_q;
    loc_len_d    = loc_len_q;
    msg_valid_d  = 1'b0;
    msg_error_d  = 1'b0;
    err_code_d   = err_code;
    place_node_d = place_node;
    msg_count_d  = msg_count;

    if (rx_valid || state_q == S_IDLE) tmo_cnt_d = '0;
    else                               tmo_cnt_d = tmo_cnt_q + 1'b1;

    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == CH_R) state_d = S_H_D;
        end
        S_H_D, S_H_M, S_H_DASH: begin
          if ((state_q == S_H_D    && rx_data == CH_D) ||
              (state_q == S_H_M    && rx_data == CH_M) ||
              (state_q == S_H_DASH && rx_data == CH_DASH)) begin
            case (state_q)
              S_H_D:   state_d = S_H_M;
              S_H_M:   state_d = S_H_DASH;
              default: begin
                state_d   = S_LOC;
                loc_buf_d = {4{CH_SPACE}};
                loc_len_d = 3'd0;
              end
            endcase
          end else begin
            // A stray 'R' is treated as the start of a fresh frame
            msg_error_d = 1'b1;
            err_code_d  = ERR_HEADER;
            state_d     = (rx_data == CH_R) ? S_H_D : S_IDLE;
          end
        end
        S_LOC: begin
          if (rx_data == CH_DASH) begin
            if (loc_len_q < 3'd3) begin
              msg_error_d = 1'b1;
              err_code_d  = ERR_LOC;
              state_d     = S_IDLE;
            end else begin
              state_d = S_TERM;
            end
          end else if (loc_len_q == 3'd4) begin
            msg_error_d = 1'b1;
            err_code_d  = ERR_LOC;
            state_d     = S_IDLE;
          end else begin
            loc_buf_d[loc_len_q[1:0]] = rx_data;
            loc_len_d                 = loc_len_q + 3'd1;
          end
        end
        S_TERM: begin
          state_d = S_IDLE;
          if (rx_data == CH_HASH) begin
            if (dec_known) begin
              msg_valid_d  = 1'b1;
              place_node_d = dec_node;
              msg_count_d  = msg_count + 1'b1;
            end else begin
              msg_error_d = 1'b1;
              err_code_d  = ERR_LOC;
            end
          end else begin
            msg_error_d = 1'b1;
            err_code_d  = ERR_TERM;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && tmo_cnt_q == TMO_LAST) begin
      msg_error_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      state_d     = S_IDLE;
      tmo_cnt_d   = '0;
    end
  end

  // State, buffer, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      loc_buf_q  <= {4{CH_SPACE}};
      loc_len_q  <= 3'd0;
      tmo_cnt_q  <= '0;
      msg_valid  <= 1'b0;
      msg_error  <= 1'b0;
      err_code   <= 2'd0;
      place_node <= 5'd0;
      busy       <= 1'b0;
      msg_count  <= '0;
    end else begin
      state_q    <= state_d;
      loc_buf_q  <= loc_buf_d;
      loc_len_q  <= loc_len_d;
      tmo_cnt_q  <= tmo_cnt_d;
      msg_valid  <= msg_valid_d;
      msg_error  <= msg_error_d;
      err_code   <= err_code_d;
      place_node <= place_node_d;
      busy       <= (state_d != S_IDLE);
      msg_count  <= msg_count_d;
    end
  end

endmodule

// File: tb/tb_rdm_rx_parser.sv
// Testbench for rdm_rx_parser: directed frames plus randomized frame traffic,
// checked every cycle against a string-based reference model of the protocol.
module tb_rdm_rx_parser;

  localparam int T     = 24;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             msg_valid;
  logic [4:0]       place_node;
  logic             msg_error;
  logic [1:0]       err_code;
  logic             busy;
  logic [CNT_W-1:0] msg_count;

  rdm_rx_parser #(.TIMEOUT_CYCLES(T), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .msg_valid  (msg_valid),
    .place_node (place_node),
    .msg_error  (msg_error),
    .err_code   (err_code),
    .busy       (busy),
    .msg_count  (msg_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: text of the frame received so far, idle clock count
  string acc;
  int    idle;
  int    node_of[string];
  bit    exp_valid, exp_error, exp_busy;
  int    exp_code, exp_node, exp_count;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    acc = ""; idle = 0;
    exp_valid = 0; exp_error = 0; exp_busy = 0;
    exp_code = 0; exp_node = 0; exp_count = 0;
  endtask

  task automatic model_err(input int code);
    exp_error = 1; exp_code = code;
  endtask

  task automatic model_append(input logic [7:0] b);
    string s;
    s = " ";
    s.putc(0, b);
    acc = {acc, s};
  endtask

  task automatic model_byte(input logic [7:0] b);
    string hdr;
    string loc;
    int    n;
    hdr = "RDM-";
    n = acc.len();
    if (n == 0) begin
      if (b == "R") acc = "R";
    end else if (n < 4) begin
      if (b == hdr[n]) model_append(b);
      else begin
        model_err(0);
        acc = (b == "R") ? "R" : "";
      end
    end else if (n > 4 && acc[n-1] == "-") begin
      if (b == "#") begin
        loc = acc.substr(4, n - 2);
        if (node_of.exists(loc)) begin
          exp_valid = 1;
          exp_node  = node_of[loc];
          exp_count = (exp_count + 1) % (1 << CNT_W);
        end else model_err(1);
      end else model_err(2);
      acc = "";
    end else begin
      if (b == "-") begin
        if (n - 4 < 3) begin model_err(1); acc = ""; end
        else model_append(b);
      end else if (n - 4 == 4) begin
        model_err(1); acc = "";
      end else model_append(b);
    end
  endtask

  task automatic model_cycle(input bit v, input logic [7:0] b);
    exp_valid = 0; exp_error = 0;
    if (v) begin
      idle = 0;
      model_byte(b);
    end else if (acc.len() > 0) begin
      idle++;
      if (idle == T) begin
        model_err(3); acc = ""; idle = 0;
      end
    end
    if (acc.len() == 0) idle = 0;
    exp_busy = (acc.len() > 0);
  endtask

  task automatic compare_outputs();
    check_val("msg_valid", msg_valid, exp_valid);
    check_val("msg_error", msg_error, exp_error);
    if (exp_error) check_val("err_code", err_code, exp_code);
    check_val("place_node", place_node, exp_node);
    check_val("busy", busy, exp_busy);
    check_val("msg_count", msg_count, exp_count);
  endtask

  // One clock: drive, let the edge pass, advance model, compare
  task automatic cycle(input bit v, input logic [7:0] b);
    rx_valid = v;
    rx_data  = v ? b : 8'($urandom);
    @(posedge clk);
    #1;
    model_cycle(v, b);
    compare_outputs();
  endtask

  task automatic send_str(input string s, input int gap_max);
    for (int i = 0; i < s.len(); i++) begin
      cycle(1'b1, s[i]);
      if (gap_max > 0 && i != s.len() - 1)
        repeat ($urandom_range(0, gap_max)) cycle(1'b0, 8'h00);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) cycle(1'b0, 8'h00);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_msg_valid", msg_valid, 0);
    check_val("rst_msg_error", msg_error, 0);
    check_val("rst_err_code", err_code, 0);
    check_val("rst_place_node", place_node, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_msg_count", msg_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_char();
    return 8'($urandom_range(33, 126));
  endfunction

  string locs[18] = '{"PSU1", "PSU2", "PSU3", "FSU1", "FSU2", "FSU3",
                      "WSU1", "WSU2", "WSU3", "MU1", "MU2", "MU3",
                      "XXX", "PSU4", "MU", "PSU12", "mu1", "FSU"};

  task automatic rand_frame();
    string f;
    int    r;
    f = {"RDM-", locs[$urandom_range(0, 17)], "-#"};
    r = $urandom_range(0, 9);
    if (r == 0) f.putc($urandom_range(0, 3), rand_char());
    if (r == 1) f.putc(f.len() - 1, rand_char());
    for (int i = 0; i < f.len(); i++) begin
      cycle(1'b1, f[i]);
      if (r == 2 && i == 5) idle_cycles(T + 2);
      else if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end
    if ($urandom_range(0, 4) == 0) cycle(1'b1, rand_char());
  endtask

  initial begin
    node_of["PSU1"] = 27; node_of["PSU2"] = 29; node_of["PSU3"] = 31;
    node_of["MU1"]  = 9;  node_of["MU2"]  = 8;  node_of["MU3"]  = 7;
    node_of["FSU1"] = 25; node_of["FSU2"] = 22; node_of["FSU3"] = 20;
    node_of["WSU1"] = 17; node_of["WSU2"] = 15; node_of["WSU3"] = 13;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    apply_reset();
    idle_cycles(2);

    // Single good frame, back-to-back bytes
    send_str("RDM-PSU1-#", 0);
    check_val("t1_valid", msg_valid, 1);
    check_val("t1_node", place_node, 27);
    check_val("t1_count", msg_count, 1);
    idle_cycles(1);

    // Two frames with no gap
    send_str("RDM-MU3-#", 0);
    check_val("t2_node_a", place_node, 7);
    send_str("RDM-WSU2-#", 0);
    check_val("t2_node_b", place_node, 15);
    check_val("t2_count", msg_count, 3);

    // Header errors, restart on stray 'R'
    send_str("RDX", 0);
    check_val("t3_hdr_err", {msg_error, err_code}, {1'b1, 2'd0});
    send_str("RDR", 0);
    check_val("t3_restart_err", {msg_error, err_code}, {1'b1, 2'd0});
    send_str("DM-FSU2-#", 0);
    check_val("t3_node", place_node, 22);

    // Unknown LOC and over-long LOC
    send_str("RDM-XXX-#", 0);
    check_val("t4_xxx_err", {msg_error, err_code}, {1'b1, 2'd1});
    check_val("t4_node_kept", place_node, 22);
    send_str("RDM-PSU12", 0);
    check_val("t4_long_err", {msg_error, err_code}, {1'b1, 2'd1});

    // Missing terminator and timeout
    send_str("RDM-FSU3-$", 0);
    check_val("t5_term_err", {msg_error, err_code}, {1'b1, 2'd2});
    send_str("RDM-FS", 0);
    idle_cycles(T);
    check_val("t5_tmo_err", {msg_error, err_code, busy}, {1'b1, 2'd3, 1'b0});

    // Reset mid-frame, then a normal frame
    send_str("RDM-WS", 0);
    apply_reset();
    send_str("RDM-WSU1-#", 0);
    check_val("t6_node", place_node, 17);
    check_val("t6_count", msg_count, 1);

    // Randomized traffic (count width small enough to wrap)
    for (int k = 0; k < 400; k++) rand_frame();
    idle_cycles(T + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
